// File: rtl/mem_stage.sv
// Memory-access stage of the 16-bit pipeline. Loads and stores go to a local
// word-addressed array over a fixed LAT-cycle access while the stage stalls
// upstream. Non-memory instructions pass straight through to write-back in one
// cycle.
module mem_stage #(
  parameter int ADDR_W = 11,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALU_result_mem,
  input  logic [15:0] Rs_data_mem,
  input  logic [2:0]  Rd_mem,
  input  logic        memRead_mem,
  input  logic        memWrite_mem,
  input  logic        regWrite_mem,
  output logic        stall,
  output logic [15:0] mem_data_wb,
  output logic [15:0] ALU_result_wb,
  output logic [2:0]  Rd_wb,
  output logic        regWrite_wb,
  output logic        memToReg_wb,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(LAT) + 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        mem_data_q, mem_data_d;
  logic [15:0]        alu_result_q, alu_result_d;
  logic [2:0]         rd_q, rd_d;
  logic               reg_write_q, reg_write_d;
  logic               mem_to_reg_q, mem_to_reg_d;
  logic               addr_err_q, addr_err_d;

  logic [15:0]        mem [DEPTH];

  logic               memop;
  logic               addr_ok;
  logic [ADDR_W-1:0]  idx;
  logic               commit;
  logic               mem_we;

  // Decode the current request and decide whether this edge commits it.
  always_comb begin
    memop   = memRead_mem | memWrite_mem;
    addr_ok = (ALU_result_mem[15:ADDR_W] == '0);
    idx     = ALU_result_mem[ADDR_W-1:0];
    commit  = ((state_q == IDLE) && memop && (LAT == 1)) ||
              ((state_q == ACCESS) && (cnt_q == CNT_W'(1)));
    // Last access cycle drops stall so upstream advances on the commit edge.
    stall   = (state_q == IDLE) ? (memop && (LAT > 1)) : (cnt_q > CNT_W'(1));
    // Gating with rst keeps an access that is being reset from landing.
    mem_we  = commit && memWrite_mem && addr_ok && !rst;
  end

  // Next-state and write-back register values.
  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_data_d   = mem_data_q;
    alu_result_d = alu_result_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    addr_err_d   = addr_err_q;

    case (state_q)
      IDLE: begin
        if (!memop) begin
          alu_result_d = ALU_result_mem;
          rd_d         = Rd_mem;
          reg_write_d  = regWrite_mem;
          mem_to_reg_d = 1'b0;
        end else if (LAT > 1) begin
          state_d     = ACCESS;
          cnt_d       = CNT_W'(LAT - 1);
          reg_write_d = 1'b0;
        end
      end
      ACCESS: begin
        cnt_d       = cnt_q - CNT_W'(1);
        reg_write_d = 1'b0;
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      alu_result_d = ALU_result_mem;
      rd_d         = Rd_mem;
      reg_write_d  = regWrite_mem;
      if (memWrite_mem) begin
        mem_to_reg_d = 1'b0;
      end else begin
        mem_to_reg_d = 1'b1;
        mem_data_d   = addr_ok ? mem[idx] : 16'h0000;
      end
      if (!addr_ok || (memRead_mem && memWrite_mem)) addr_err_d = 1'b1;
    end
  end

  // Control and write-back registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_data_q   <= '0;
      alu_result_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_data_q   <= mem_data_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Data array write port.
  // NOTE: the array has no reset; clearing it would turn a RAM into flops and
  // its contents are defined only by stores.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= Rs_data_mem;
  end

  assign mem_data_wb   = mem_data_q;
  assign ALU_result_wb = alu_result_q;
  assign Rd_wb         = rd_q;
  assign regWrite_wb   = reg_write_q;
  assign memToReg_wb   = mem_to_reg_q;
  assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a LAT=2 instance driven from a per-cycle vector
// table plus a reset-abort sequence, and a LAT=3 instance for the longer stall.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // LAT=2 instance signals
  logic [15:0] a_alu, a_data;
  logic [2:0]  a_rdst;
  logic        a_rd, a_wr, a_rw;
  logic        a_stall, a_rw_wb, a_m2r, a_err;
  logic [15:0] a_mem_wb, a_alu_wb;
  logic [2:0]  a_rd_wb;

  // LAT=3 instance signals
  logic [15:0] b_alu, b_data;
  logic [2:0]  b_rdst;
  logic        b_rd, b_wr, b_rw;
  logic        b_stall, b_rw_wb, b_m2r, b_err;
  logic [15:0] b_mem_wb, b_alu_wb;
  logic [2:0]  b_rd_wb;

  mem_stage #(.ADDR_W(11), .LAT(2)) u_a (
    .clk(clk), .rst(rst),
    .ALU_result_mem(a_alu), .Rs_data_mem(a_data), .Rd_mem(a_rdst),
    .memRead_mem(a_rd), .memWrite_mem(a_wr), .regWrite_mem(a_rw),
    .stall(a_stall), .mem_data_wb(a_mem_wb), .ALU_result_wb(a_alu_wb),
    .Rd_wb(a_rd_wb), .regWrite_wb(a_rw_wb), .memToReg_wb(a_m2r),
    .addr_err(a_err)
  );

  mem_stage #(.ADDR_W(11), .LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .ALU_result_mem(b_alu), .Rs_data_mem(b_data), .Rd_mem(b_rdst),
    .memRead_mem(b_rd), .memWrite_mem(b_wr), .regWrite_mem(b_rw),
    .stall(b_stall), .mem_data_wb(b_mem_wb), .ALU_result_wb(b_alu_wb),
    .Rd_wb(b_rd_wb), .regWrite_wb(b_rw_wb), .memToReg_wb(b_m2r),
    .addr_err(b_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] data;
    logic [2:0]  rdst;
    logic        e_stall;
    logic [15:0] e_mem;
    logic [15:0] e_alu;
    logic [2:0]  e_rd;
    logic        e_rw;
    logic        e_m2r;
    logic        e_err;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(input logic rd, input logic wr, input logic rw,
                              input logic [15:0] addr, input logic [15:0] data,
                              input logic [2:0] rdst, input logic e_stall,
                              input logic [15:0] e_mem, input logic [15:0] e_alu,
                              input logic [2:0] e_rd, input logic e_rw,
                              input logic e_m2r, input logic e_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rw = rw; v.addr = addr; v.data = data; v.rdst = rdst;
    v.e_stall = e_stall; v.e_mem = e_mem; v.e_alu = e_alu; v.e_rd = e_rd;
    v.e_rw = e_rw; v.e_m2r = e_m2r; v.e_err = e_err;
    return v;
  endfunction

  // Each vector: inputs held for one cycle, stall checked mid-cycle, wb outputs
  // checked after the following rising edge.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      a_rd = vecs[i].rd; a_wr = vecs[i].wr; a_rw = vecs[i].rw;
      a_alu = vecs[i].addr; a_data = vecs[i].data; a_rdst = vecs[i].rdst;
      #1;
      check($sformatf("v%0d stall", i), {15'd0, a_stall}, {15'd0, vecs[i].e_stall});
      @(negedge clk);
      check($sformatf("v%0d mem_data_wb", i), a_mem_wb, vecs[i].e_mem);
      check($sformatf("v%0d ALU_result_wb", i), a_alu_wb, vecs[i].e_alu);
      check($sformatf("v%0d Rd_wb", i), {13'd0, a_rd_wb}, {13'd0, vecs[i].e_rd});
      check($sformatf("v%0d regWrite_wb", i), {15'd0, a_rw_wb}, {15'd0, vecs[i].e_rw});
      check($sformatf("v%0d memToReg_wb", i), {15'd0, a_m2r}, {15'd0, vecs[i].e_m2r});
      check($sformatf("v%0d addr_err", i), {15'd0, a_err}, {15'd0, vecs[i].e_err});
    end
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, " stall"}, {15'd0, a_stall}, 16'h0);
    check({tag, " mem_data_wb"}, a_mem_wb, 16'h0);
    check({tag, " ALU_result_wb"}, a_alu_wb, 16'h0);
    check({tag, " Rd_wb"}, {13'd0, a_rd_wb}, 16'h0);
    check({tag, " regWrite_wb"}, {15'd0, a_rw_wb}, 16'h0);
    check({tag, " memToReg_wb"}, {15'd0, a_m2r}, 16'h0);
    check({tag, " addr_err"}, {15'd0, a_err}, 16'h0);
  endtask

  initial begin
    //              rd wr rw addr      data      rdst st mem       alu       rd rw m2r err
    vecs[0]  = mk(0, 0, 1, 16'h1234, 16'h0000, 3'd5, 0, 16'h0000, 16'h1234, 3'd5, 1, 0, 0);
    vecs[1]  = mk(0, 1, 0, 16'h0010, 16'hBEEF, 3'd0, 1, 16'h0000, 16'h1234, 3'd5, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 16'h0010, 16'hBEEF, 3'd0, 0, 16'h0000, 16'h0010, 3'd0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 1, 16'h0010, 16'h0000, 3'd3, 1, 16'h0000, 16'h0010, 3'd0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 1, 16'h0010, 16'h0000, 3'd3, 0, 16'hBEEF, 16'h0010, 3'd3, 1, 1, 0);
    vecs[5]  = mk(0, 0, 1, 16'h00FF, 16'h0000, 3'd2, 0, 16'hBEEF, 16'h00FF, 3'd2, 1, 0, 0);
    vecs[6]  = mk(0, 1, 0, 16'h0020, 16'h1357, 3'd0, 1, 16'hBEEF, 16'h00FF, 3'd2, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 16'h0020, 16'h1357, 3'd0, 0, 16'hBEEF, 16'h0020, 3'd0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 1, 16'h0004, 16'h00AA, 3'd7, 1, 16'hBEEF, 16'h0020, 3'd0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 1, 16'h0004, 16'h00AA, 3'd7, 0, 16'hBEEF, 16'h0004, 3'd7, 1, 0, 1);
    vecs[10] = mk(1, 0, 1, 16'h0004, 16'h0000, 3'd1, 1, 16'hBEEF, 16'h0004, 3'd7, 0, 0, 1);
    vecs[11] = mk(1, 0, 1, 16'h0004, 16'h0000, 3'd1, 0, 16'h00AA, 16'h0004, 3'd1, 1, 1, 1);
    // after reset-abort sequence
    vecs[12] = mk(0, 1, 0, 16'h0000, 16'h0A0A, 3'd0, 1, 16'h0000, 16'h0000, 3'd0, 0, 0, 0);
    vecs[13] = mk(0, 1, 0, 16'h0000, 16'h0A0A, 3'd0, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 0);
    vecs[14] = mk(0, 1, 0, 16'h0800, 16'h1111, 3'd0, 1, 16'h0000, 16'h0000, 3'd0, 0, 0, 0);
    vecs[15] = mk(0, 1, 0, 16'h0800, 16'h1111, 3'd0, 0, 16'h0000, 16'h0800, 3'd0, 0, 0, 1);
    vecs[16] = mk(1, 0, 1, 16'h0000, 16'h0000, 3'd4, 1, 16'h0000, 16'h0800, 3'd0, 0, 0, 1);
    vecs[17] = mk(1, 0, 1, 16'h0000, 16'h0000, 3'd4, 0, 16'h0A0A, 16'h0000, 3'd4, 1, 1, 1);
    vecs[18] = mk(1, 0, 1, 16'h0800, 16'h0000, 3'd6, 1, 16'h0A0A, 16'h0000, 3'd4, 0, 1, 1);
    vecs[19] = mk(1, 0, 1, 16'h0800, 16'h0000, 3'd6, 0, 16'h0000, 16'h0800, 3'd6, 1, 1, 1);
    vecs[20] = mk(1, 0, 1, 16'h0020, 16'h0000, 3'd5, 1, 16'h0000, 16'h0800, 3'd6, 0, 1, 1);
    vecs[21] = mk(1, 0, 1, 16'h0020, 16'h0000, 3'd5, 0, 16'h1357, 16'h0020, 3'd5, 1, 1, 1);
    vecs[22] = mk(0, 0, 0, 16'h4321, 16'h0000, 3'd0, 0, 16'h1357, 16'h4321, 3'd0, 0, 0, 1);

    rst = 1'b1;
    a_rd = 0; a_wr = 0; a_rw = 0; a_alu = '0; a_data = '0; a_rdst = '0;
    b_rd = 0; b_wr = 0; b_rw = 0; b_alu = '0; b_data = '0; b_rdst = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_a_zero("reset");
    check("reset b regWrite_wb", {15'd0, b_rw_wb}, 16'h0);
    check("reset b stall", {15'd0, b_stall}, 16'h0);

    run_vecs(0, 12);

    // Reset during the ACCESS phase of a store: nothing is written.
    a_rd = 0; a_wr = 1; a_rw = 0; a_alu = 16'h0020; a_data = 16'h5555; a_rdst = 3'd0;
    #1;
    check("abort stall before", {15'd0, a_stall}, 16'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    a_wr = 0; a_alu = '0; a_data = '0;
    #1;
    check_a_zero("abort");
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_vecs(12, 23);

    // LAT=3: store 0x7777 @5, then load it back; stall 2 cycles each.
    begin
      logic        in_rd [6] = '{0, 0, 0, 1, 1, 1};
      logic        in_wr [6] = '{1, 1, 1, 0, 0, 0};
      logic        e_st  [6] = '{1, 1, 0, 1, 1, 0};
      logic        e_rw  [6] = '{0, 0, 0, 0, 0, 1};
      for (int i = 0; i < 6; i++) begin
        b_rd = in_rd[i]; b_wr = in_wr[i]; b_rw = in_rd[i];
        b_alu = 16'h0005; b_data = in_wr[i] ? 16'h7777 : 16'h0000;
        b_rdst = in_rd[i] ? 3'd2 : 3'd0;
        #1;
        check($sformatf("lat3 c%0d stall", i), {15'd0, b_stall}, {15'd0, e_st[i]});
        @(negedge clk);
        check($sformatf("lat3 c%0d regWrite_wb", i), {15'd0, b_rw_wb}, {15'd0, e_rw[i]});
      end
      check("lat3 mem_data_wb", b_mem_wb, 16'h7777);
      check("lat3 memToReg_wb", {15'd0, b_m2r}, 16'h1);
      check("lat3 Rd_wb", {13'd0, b_rd_wb}, 16'h2);
      check("lat3 addr_err", {15'd0, b_err}, 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
